// File: rtl/display_driver_if.sv
// Bus between the calculator controller and the display driver: result handshake,
// converted BCD result and the multiplexed seven-segment drive.
interface display_driver_if;
    logic [15:0] display_value;
    logic        load;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic        sign_out;
    logic [6:0]  seg;
    logic [5:0]  an;

    modport master (
        output display_value, load,
        input  busy, done, bcd_out, sign_out, seg, an
    );

    modport slave (
        input  display_value, load,
        output busy, done, bcd_out, sign_out, seg, an
    );
endinterface

// File: rtl/display_driver.sv
// Sign-magnitude result to BCD via iterative double-dabble, then a free-running
// six-digit seven-segment scan with leading-zero blanking and a minus digit.
module display_driver #(
    parameter int SCAN_DIV = 1000
) (
    input logic             clk,
    input logic             RST,
    display_driver_if.slave bus
);
    typedef enum logic {IDLE, CONVERT} state_t;

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t      state, state_next;
    logic [14:0] mag_sr;
    logic [19:0] scratch;
    logic [3:0]  iter;
    logic        sign_lat;
    logic        mag_nz;
    logic [19:0] adjusted;
    logic [34:0] shifted;

    logic [CW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic [19:0]   digit_shift;
    logic [6:0]    seg_next;
    logic [5:0]    an_next;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    assign bus.busy = (state == CONVERT);

    // One double-dabble step: correct every nibble, then shift magnitude into the BCD scratch.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shifted = {adjusted, mag_sr} << 1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.load) state_next = CONVERT;
            CONVERT: if (iter == 4'd14) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Published result only changes on the final iteration, so the display never sees partial values.
    always_ff @(posedge clk) begin
        if (RST) begin
            mag_sr       <= '0;
            scratch      <= '0;
            iter         <= '0;
            sign_lat     <= 1'b0;
            mag_nz       <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd_out  <= '0;
            bus.sign_out <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        mag_sr   <= bus.display_value[14:0];
                        sign_lat <= bus.display_value[15];
                        mag_nz   <= (bus.display_value[14:0] != 15'd0);
                        scratch  <= '0;
                        iter     <= '0;
                    end
                end
                CONVERT: begin
                    scratch <= shifted[34:15];
                    mag_sr  <= shifted[14:0];
                    iter    <= iter + 4'd1;
                    if (iter == 4'd14) begin
                        bus.bcd_out  <= shifted[34:15];
                        bus.sign_out <= sign_lat & mag_nz;
                        bus.done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A digit is blank when it and everything above it is zero; units is always drawn.
    always_comb begin
        seg_next    = '0;
        an_next     = '0;
        digit_shift = bus.bcd_out >> {digit_idx, 2'b00};
        if (digit_idx == 3'd5) begin
            an_next  = 6'b100000;
            seg_next = bus.sign_out ? 7'h40 : 7'h00;
        end else if (digit_idx < 3'd5) begin
            an_next = 6'b000001 << digit_idx;
            if (digit_idx == 3'd0 || digit_shift != 20'd0)
                seg_next = glyph(digit_shift[3:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            bus.an  <= 6'b000001;
            bus.seg <= 7'h3F;
        end else begin
            bus.an  <= an_next;
            bus.seg <= seg_next;
        end
    end
endmodule

// File: tb/tb_display_driver.sv
// Table-driven conversions with a result scoreboard, scan/blanking checks and
// hand-written sequences for ignored loads and reset mid-conversion.
module tb_display_driver;
    localparam int SCAN_DIV = 4;

    typedef struct packed {
        logic [15:0]     value;
        logic [19:0]     bcd;
        logic            sign;
        logic [5:0][6:0] segs;
    } vec_t;

    typedef struct packed {
        logic [19:0] bcd;
        logic        sign;
    } exp_t;

    logic clk = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [19:0] last_bcd = '0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    display_driver_if dd();

    display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk),
        .RST(RST),
        .bus(dd)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input bit push,
                                 input logic [19:0] eb, input logic es);
        exp_t e;
        @(negedge clk);
        dd.display_value = v;
        dd.load = 1'b1;
        if (push) begin
            e.bcd  = eb;
            e.sign = es;
            sb.push_back(e);
        end
        @(negedge clk);
        dd.load = 1'b0;
    endtask

    // Called n negedges after the load edge; done must show up at negedge 15.
    task automatic waitDone(input int start_cnt);
        int   cnt;
        exp_t e;
        cnt = start_cnt;
        while (dd.done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (dd.done !== 1'b1) begin
            checkOutput("done_timeout", 32'(dd.done), 32'd1);
        end else begin
            checkOutput("done_latency", 32'(cnt), 32'd15);
            checkOutput("busy_at_done", 32'(dd.busy), 32'd0);
            if (sb.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("bcd_out", 32'(dd.bcd_out), 32'(e.bcd));
                checkOutput("sign_out", 32'(dd.sign_out), 32'(e.sign));
                last_bcd = e.bcd;
            end
        end
    endtask

    task automatic checkDigits(input logic [5:0][6:0] segs);
        logic [5:0] prev;
        int run, p;
        bit seen_change;
        @(negedge clk);
        checkOutput("done_width", 32'(dd.done), 32'd0);
        prev = dd.an;
        run = 1;
        seen_change = 1'b0;
        for (int k = 0; k < 28; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (dd.an !== prev) begin
                    checkOutput("an_walk", 32'(dd.an), 32'({prev[4:0], prev[5]}));
                    if (seen_change) checkOutput("an_period", 32'(run), 32'(SCAN_DIV));
                    seen_change = 1'b1;
                    run = 1;
                    prev = dd.an;
                end else begin
                    run++;
                end
            end
            p = -1;
            for (int i = 0; i < 6; i++) if (dd.an === (6'b000001 << i)) p = i;
            if (p < 0) checkOutput("an_onehot", 32'(dd.an), 32'd1);
            else       checkOutput($sformatf("seg_digit%0d", p), 32'(dd.seg), 32'(segs[p]));
        end
    endtask

    initial begin
        int  saw;
        RST = 1'b1;
        dd.load = 1'b0;
        dd.display_value = '0;

        vecs[0] = '{16'h000C, 20'h00012, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B}};
        vecs[1] = '{16'hFFFF, 20'h32767, 1'b1, {7'h40, 7'h4F, 7'h5B, 7'h07, 7'h7D, 7'h07}};
        vecs[2] = '{16'h8000, 20'h00000, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{16'h0007, 20'h00007, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07}};
        vecs[4] = '{16'h1388, 20'h05000, 1'b0, {7'h00, 7'h00, 7'h6D, 7'h3F, 7'h3F, 7'h3F}};
        vecs[5] = '{16'h800A, 20'h00010, 1'b1, {7'h40, 7'h00, 7'h00, 7'h00, 7'h06, 7'h3F}};

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(dd.busy), 32'd0);
        checkOutput("rst_done", 32'(dd.done), 32'd0);
        checkOutput("rst_bcd", 32'(dd.bcd_out), 32'd0);
        checkOutput("rst_sign", 32'(dd.sign_out), 32'd0);
        checkOutput("rst_an", 32'(dd.an), 32'h01);
        checkOutput("rst_seg", 32'(dd.seg), 32'h3F);
        RST = 1'b0;

        for (int v = 0; v < 6; v++) begin
            $display("[TB] converting %04h", vecs[v].value);
            applyStimulus(vecs[v].value, 1'b1, vecs[v].bcd, vecs[v].sign);
            checkOutput("busy_after_load", 32'(dd.busy), 32'd1);
            checkOutput("bcd_hold_start", 32'(dd.bcd_out), 32'(last_bcd));
            waitDone(0);
            checkDigits(vecs[v].segs);
        end

        // Second load during conversion must be dropped without disturbing the result.
        applyStimulus(16'h115C, 1'b1, 20'h04444, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("bcd_hold_mid", 32'(dd.bcd_out), 32'(last_bcd));
        dd.display_value = 16'h87CE;
        dd.load = 1'b1;
        @(negedge clk);
        dd.load = 1'b0;
        waitDone(5);
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (dd.done === 1'b1) saw++;
        end
        checkOutput("ignored_load_no_done", 32'(saw), 32'd0);
        applyStimulus(16'h87CE, 1'b1, 20'h01998, 1'b1);
        waitDone(0);

        // Reset eight cycles into a conversion aborts it.
        applyStimulus(16'h0064, 1'b0, 20'h0, 1'b0);
        repeat (7) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(dd.busy), 32'd0);
        checkOutput("midrst_done", 32'(dd.done), 32'd0);
        checkOutput("midrst_bcd", 32'(dd.bcd_out), 32'd0);
        checkOutput("midrst_sign", 32'(dd.sign_out), 32'd0);
        checkOutput("midrst_an", 32'(dd.an), 32'h01);
        checkOutput("midrst_seg", 32'(dd.seg), 32'h3F);
        RST = 1'b0;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (dd.done === 1'b1) saw++;
        end
        checkOutput("midrst_no_done", 32'(saw), 32'd0);
        checkOutput("midrst_bcd_stays", 32'(dd.bcd_out), 32'd0);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
